eth_pcs_rx_gearbox: RTL and testbench

RX gearbox for the 10GBASE-R PCS receive path. It sits between the SERDES parallel interface and `eth_pcs_rx_block_synch`. It accumulates fixed-width SERDES words into a bit buffer, extracts 66-bit blocks as a 2-bit sync header plus 64-bit payload, and emits them with a valid strobe. It also accepts the one-bit slip request from the block synchronizer, which shifts block alignment by one bit per request until lock is reached.

---
 rtl/eth_pcs_rx_gearbox.sv | 79 +++++++
 tb/tb_eth_pcs_rx_gearbox.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_rx_gearbox.sv
// 10GBASE-R PCS receive gearbox: packs SERDES words into a bit buffer and cuts
// 66-bit blocks (2-bit sync header + 64-bit payload), with one-bit slip for block lock.
module eth_pcs_rx_gearbox #(
  parameter int unsigned W_IN       = 32,
  parameter int unsigned W_SYNC     = 2,
  parameter int unsigned W_BLK_DATA = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [W_IN-1:0]       i_data,
  input  logic                  i_slip,
  output logic                  o_valid,
  output logic [W_SYNC-1:0]     o_sync_hdr,
  output logic [W_BLK_DATA-1:0] o_data
);

  localparam int unsigned BLK_W  = W_SYNC + W_BLK_DATA;
  localparam int unsigned BUF_W  = W_IN + BLK_W - 1;
  localparam int unsigned FILL_W = $clog2(W_IN + BLK_W);

  logic [BUF_W-1:0]      bits_q;
  logic [BUF_W-1:0]      bits_d;
  logic [FILL_W-1:0]     fill_q;
  logic [FILL_W-1:0]     fill_d;
  logic                  pend_q;
  logic                  pend_d;
  logic                  valid_d;
  logic [W_SYNC-1:0]     hdr_d;
  logic [W_BLK_DATA-1:0] data_d;

  // Append, then optional one-bit slip, then cut a block if one is complete.
  // Bits at or above fill stay zero, so appending is a plain OR at the fill point.
  always_comb begin
    bits_d  = bits_q;
    fill_d  = fill_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    hdr_d   = o_sync_hdr;
    data_d  = o_data;
    if (i_valid) begin
      bits_d = bits_q | (BUF_W'(i_data) << fill_q);
      fill_d = fill_q + FILL_W'(W_IN);
      if (i_slip || pend_q) begin
        bits_d = bits_d >> 1;
        fill_d = fill_d - FILL_W'(1);
      end
      pend_d = 1'b0;
      if (fill_d >= FILL_W'(BLK_W)) begin
        valid_d = 1'b1;
        hdr_d   = bits_d[W_SYNC-1:0];
        data_d  = bits_d[BLK_W-1:W_SYNC];
        bits_d  = bits_d >> BLK_W;
        fill_d  = fill_d - FILL_W'(BLK_W);
      end
    end else if (i_slip) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bits_q     <= '0;
      fill_q     <= '0;
      pend_q     <= 1'b0;
      o_valid    <= 1'b0;
      o_sync_hdr <= '0;
      o_data     <= '0;
    end else begin
      bits_q     <= bits_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      o_valid    <= valid_d;
      o_sync_hdr <= hdr_d;
      o_data     <= data_d;
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_gearbox.sv
// Directed bench for eth_pcs_rx_gearbox (W_IN=32): builds line bit streams of
// known 66-bit blocks and checks the cut blocks, their timing and slip behaviour.
module tb_eth_pcs_rx_gearbox;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;
  logic        slip = 1'b0;
  logic        blk_valid;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_data;

  int checks = 0;
  int errors = 0;
  int words_acc = 0;
  int lock_slips = 0;
  int word_slips = 0;
  logic first_slip = 1'b0;
  logic last_valid = 1'b0;
  logic mon_on = 1'b0;

  bit          stream[$];
  logic [1:0]  rx_hdr[$];
  logic [63:0] rx_data[$];
  int          rx_word[$];

  eth_pcs_rx_gearbox #(.W_IN(32)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_valid    (valid),
    .i_data     (data),
    .i_slip     (slip),
    .o_valid    (blk_valid),
    .o_sync_hdr (blk_hdr),
    .o_data     (blk_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    last_valid <= valid;
    if (rst) words_acc <= 0;
    else if (valid) words_acc <= words_acc + 1;
  end

  // Record strobes; a cycle after an idle input cycle must never carry a block.
  always @(negedge clk) begin
    if (mon_on) begin
      if (blk_valid === 1'b1) begin
        rx_hdr.push_back(blk_hdr);
        rx_data.push_back(blk_data);
        rx_word.push_back(words_acc);
      end
      if (!last_valid) check("gap_quiet", blk_valid, 1'b0);
    end
  end

  task automatic clear_rx;
    rx_hdr.delete();
    rx_data.delete();
    rx_word.delete();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s);
    @(negedge clk);
    valid = v;
    data  = d;
    slip  = s;
    if (lock_slips > 0 && blk_valid === 1'b1) begin
      slip = 1'b1;
      lock_slips--;
    end
    if (v && word_slips > 0) begin
      slip = 1'b1;
      word_slips--;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; slip = 1'b0; data = '0;
    @(negedge clk);
    rst = 1'b0;
    clear_rx();
    mon_on = 1'b1;
  endtask

  task automatic push_block(input logic [1:0] hdr, input logic [63:0] pay);
    for (int i = 0; i < 2; i++) stream.push_back(hdr[i]);
    for (int i = 0; i < 64; i++) stream.push_back(pay[i]);
  endtask

  // Sends the queued bits LSB-first, zero-padding the last word; a non-zero
  // gap_every inserts an idle cycle (with junk data) before every gap_every-th word.
  task automatic send_stream(input int gap_every);
    logic [31:0] w;
    int n;
    n = 0;
    while (stream.size() > 0) begin
      n++;
      if (gap_every > 0 && (n % gap_every) == 0) drive(1'b0, 32'hA5A5_5A5A, 1'b0);
      w = '0;
      for (int i = 0; i < 32; i++) if (stream.size() > 0) w[i] = stream.pop_front();
      drive(1'b1, w, (n == 1) ? first_slip : 1'b0);
    end
    repeat (3) drive(1'b0, 32'h0, 1'b0);
    first_slip = 1'b0;
  endtask

  task automatic check_blocks(input string name, input int first_idx,
                              input logic [1:0] hdr, input logic [63:0] first_pay, input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = first_idx + i;
      if (idx < rx_data.size()) begin
        check($sformatf("%s_hdr%0d", name, idx), rx_hdr[idx], hdr);
        check($sformatf("%s_data%0d", name, idx), rx_data[idx], first_pay + 64'(i));
      end else begin
        check($sformatf("%s_present%0d", name, idx), rx_data.size(), idx + 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", blk_valid, 1'b0);
    check("rst_hdr", blk_hdr, 2'b00);
    check("rst_data", blk_data, 64'h0);

    // Aligned stream: 16 blocks in 33 words
    for (int k = 0; k < 16; k++) push_block(2'b01, 64'(k));
    send_stream(0);
    check("aligned_count", rx_data.size(), 16);
    if (rx_word.size() > 0) check("aligned_first_word", rx_word[0], 3);
    check_blocks("aligned", 0, 2'b01, 64'd0, 16);
    check("hold", {blk_valid, blk_hdr, blk_data}, {1'b0, 2'b01, 64'd15});

    // Fill back at zero: the next block is cut at the third following word
    clear_rx();
    push_block(2'b10, 64'hDEAD_BEEF_0123_4567);
    send_stream(0);
    check("cont_count", rx_data.size(), 1);
    if (rx_word.size() > 0) check("cont_word", rx_word[0], 36);
    check_blocks("cont", 0, 2'b10, 64'hDEAD_BEEF_0123_4567, 1);

    // Slip to lock: 5 garbage bits, slip on each of the first 5 strobes
    do_reset();
    stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    stream.push_back(1'b1); stream.push_back(1'b0);
    for (int k = 0; k < 16; k++) push_block(2'b01, 64'(k));
    lock_slips = 5;
    send_stream(0);
    check("lock_count", rx_data.size(), 16);
    check_blocks("lock", 5, 2'b01, 64'd5, 11);

    // Input gaps
    do_reset();
    for (int k = 0; k < 16; k++) push_block(2'b01, 64'(k));
    send_stream(3);
    check("gap_count", rx_data.size(), 16);
    check_blocks("gap", 0, 2'b01, 64'd0, 16);

    // Slip during idle is held pending and applied on the next valid word
    do_reset();
    drive(1'b0, 32'hFFFF_FFFF, 1'b1);
    drive(1'b0, 32'hFFFF_FFFF, 1'b0);
    stream.push_back(1'b1);
    push_block(2'b01, 64'h0123_4567_89AB_CDEF);
    push_block(2'b01, 64'h2);
    send_stream(0);
    check("idle_count", rx_data.size(), 2);
    if (rx_word.size() > 0) check("idle_word", rx_word[0], 3);
    check_blocks("idle", 0, 2'b01, 64'h0123_4567_89AB_CDEF, 1);

    // Pending slip merged with a concurrent slip discards only one bit
    do_reset();
    drive(1'b0, 32'h0, 1'b1);
    stream.push_back(1'b0);
    push_block(2'b10, 64'h5555_AAAA_0F0F_F0F0);
    first_slip = 1'b1;
    send_stream(0);
    check("merge_count", rx_data.size(), 1);
    check_blocks("merge", 0, 2'b10, 64'h5555_AAAA_0F0F_F0F0, 1);

    // 66 slips, one per word: realigned with exactly one block dropped
    do_reset();
    for (int k = 0; k < 40; k++) push_block(2'b01, 64'(k));
    word_slips = 66;
    send_stream(0);
    check("wrap_count", rx_data.size(), 39);
    check_blocks("wrap", 34, 2'b01, 64'd35, 5);

    // Reset mid-stream with fill=40 and a slip request
    do_reset();
    for (int k = 0; k < 13; k++) push_block(2'b01, 64'(k + 100));
    repeat (26) void'(stream.pop_back());
    send_stream(0);
    check("pre_rst_data", {blk_hdr, blk_data}, {2'b01, 64'd111});
    rst = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; slip = 1'b0;
    check("midrst_out", {blk_valid, blk_hdr, blk_data}, 67'h0);
    clear_rx();
    push_block(2'b01, 64'hCAFE);
    send_stream(0);
    check("post_rst_count", rx_data.size(), 1);
    if (rx_word.size() > 0) check("post_rst_word", rx_word[0], 3);
    check_blocks("post_rst", 0, 2'b01, 64'hCAFE, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
